// File: rtl/param_step_counter_pkg.sv
// Shared definitions for the step counter: mode encodings and the prescaler
// width helper.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP1  = 2'b01,
    MODE_UPS  = 2'b10,
    MODE_DNS  = 2'b11
  } mode_e;

  // Bits needed to hold the values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/param_step_counter_if.sv
// Control and status bundle of the step counter; master drives the controls,
// slave (the counter) returns the count, terminal-count and tick.
interface param_step_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             sync_clr;
  logic [1:0]       sel;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             tick;

  modport master (
    output en, sync_clr, sel, load, load_val,
    input  Q, tc, tick
  );

  modport slave (
    input  en, sync_clr, sel, load, load_val,
    output Q, tc, tick
  );
endinterface

// File: rtl/param_step_counter_tick_gen.sv
// Tick prescaler: counts 0..DIV-1 while enabled and emits a registered
// one-cycle tick on each wrap. Disabled cycles freeze both phase and tick.
module tick_gen
  import counter_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic Clear_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              PW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (pre == LAST) begin
        pre  <= '0;
        tick <= 1'b1;
      end else begin
        pre  <= pre + 1'b1;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_step_counter.sv
// Up/down step counter advanced by an internal prescaler tick, with
// synchronous clear, parallel load, and wrap or saturate on overflow.
module param_step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 50_000_000,
  parameter int STEP  = 2,
  parameter int WRAP  = 1
) (
  input logic                clk,
  input logic                Clear_n,
  param_step_counter_if.slave bus
);

  localparam logic [WIDTH:0] MAX_Q  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH + 1)'(1);

  logic             tick;
  logic             count;
  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   k;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk     (clk),
    .Clear_n (Clear_n),
    .clr     (bus.sync_clr),
    .en      (bus.en),
    .tick    (tick)
  );

  // A tick held through an en=0 stretch is spent only once en returns.
  assign count = bus.en & tick;
  assign mode  = mode_e'(bus.sel);
  assign q_ext = {1'b0, q};

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    k       = (mode == MODE_UP1) ? ONE_X : STEP_X;
    sum     = '0;
    diff    = '0;
    q_next  = q;
    tc_next = 1'b0;
    unique case (mode)
      MODE_HOLD: ;
      MODE_UP1, MODE_UPS: begin
        sum = q_ext + k;
        if (sum > MAX_Q) begin
          tc_next = 1'b1;
          q_next  = (WRAP != 0) ? sum[WIDTH-1:0] : MAX_Q[WIDTH-1:0];
        end else begin
          q_next  = sum[WIDTH-1:0];
        end
      end
      MODE_DNS: begin
        // Modulo-2**WIDTH difference is already the wrapped result.
        diff = q - k[WIDTH-1:0];
        if (q_ext < k) begin
          tc_next = 1'b1;
          q_next  = (WRAP != 0) ? diff : '0;
        end else begin
          q_next  = diff;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (bus.sync_clr) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (bus.load) begin
      q  <= bus.load_val;
      tc <= 1'b0;
    end else if (count) begin
      q  <= q_next;
      tc <= tc_next;
    end else begin
      tc <= 1'b0;
    end
  end

  assign bus.Q    = q;
  assign bus.tc   = tc;
  assign bus.tick = tick;

endmodule

// File: tb/tb_param_step_counter.sv
// Bench for param_step_counter: wrapping and saturating instances side by
// side, directed vectors plus randomized traffic against an integer model.
module tb_param_step_counter;
  import counter_pkg::*;

  localparam int W    = 4;
  localparam int DIV  = 4;
  localparam int STEP = 2;
  localparam int QMAX = (1 << W) - 1;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         en       = 1'b1;
  logic         sync_clr = 1'b0;
  logic         load     = 1'b0;
  logic [1:0]   sel      = 2'b00;
  logic [W-1:0] load_val = '0;

  always #5 clk = ~clk;

  param_step_counter_if #(.WIDTH(W)) bus_w ();
  param_step_counter_if #(.WIDTH(W)) bus_s ();

  assign bus_w.en = en;  assign bus_w.sync_clr = sync_clr; assign bus_w.sel = sel;
  assign bus_w.load = load; assign bus_w.load_val = load_val;
  assign bus_s.en = en;  assign bus_s.sync_clr = sync_clr; assign bus_s.sel = sel;
  assign bus_s.load = load; assign bus_s.load_val = load_val;

  param_step_counter #(.WIDTH(W), .DIV(DIV), .STEP(STEP), .WRAP(1)) dut_w (
    .clk(clk), .Clear_n(rst_n), .bus(bus_w.slave)
  );
  param_step_counter #(.WIDTH(W), .DIV(DIV), .STEP(STEP), .WRAP(0)) dut_s (
    .clk(clk), .Clear_n(rst_n), .bus(bus_s.slave)
  );

  // Reference model: index 0 wraps, index 1 saturates.
  int m_pre     = 0;
  bit m_tick    = 1'b0;
  int m_q  [2]  = '{0, 0};
  bit m_tc [2]  = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0; m_tick = 1'b0; m_q = '{0, 0}; m_tc = '{1'b0, 1'b0};
    end else begin
      bit fire;
      int delta;
      int raw;
      fire = en && m_tick;
      if (sync_clr) begin
        m_pre = 0; m_tick = 1'b0;
      end else if (en) begin
        m_tick = (m_pre == DIV - 1);
        m_pre  = (m_pre + 1) % DIV;
      end
      case (sel)
        2'b01:   delta = 1;
        2'b10:   delta = STEP;
        2'b11:   delta = -STEP;
        default: delta = 0;
      endcase
      for (int i = 0; i < 2; i++) begin
        if (sync_clr) begin
          m_q[i] = 0; m_tc[i] = 1'b0;
        end else if (load) begin
          m_q[i] = int'(load_val); m_tc[i] = 1'b0;
        end else if (fire && delta != 0) begin
          raw = m_q[i] + delta;
          if (raw >= 0 && raw <= QMAX) begin
            m_q[i] = raw; m_tc[i] = 1'b0;
          end else begin
            m_tc[i] = 1'b1;
            if (i == 0) m_q[i] = (raw + QMAX + 1) % (QMAX + 1);
            else        m_q[i] = (raw < 0) ? 0 : QMAX;
          end
        end else begin
          m_tc[i] = 1'b0;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model_q_wrap", 32'(bus_w.Q), m_q[0]);
    check("model_tc_wrap", 32'(bus_w.tc), 32'(m_tc[0]));
    check("model_q_sat", 32'(bus_s.Q), m_q[1]);
    check("model_tc_sat", 32'(bus_s.tc), 32'(m_tc[1]));
    check("model_tick", 32'(bus_w.tick), 32'(m_tick));
  endtask

  task automatic step();
    @(negedge clk);
    cmp_model();
  endtask

  // Advance to the next tick cycle, optionally load in exactly that cycle,
  // then pass the counting edge.
  task automatic next_count(input logic ld, input logic [W-1:0] lv);
    int guard;
    guard = 0;
    while (!m_tick && guard < 3 * DIV) begin
      step();
      guard++;
    end
    check("tick_due", 32'(bus_w.tick), 32'd1);
    load = ld; load_val = lv;
    step();
    load = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   sel;
    logic         ld;
    logic [W-1:0] lv;
    logic [W-1:0] exp_q;
    logic         exp_tc;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{2'b10, 1'b0, 4'd0, 4'd2,  1'b0}, '{2'b10, 1'b0, 4'd0, 4'd4,  1'b0},
      '{2'b10, 1'b0, 4'd0, 4'd6,  1'b0}, '{2'b10, 1'b0, 4'd0, 4'd8,  1'b0},
      '{2'b10, 1'b0, 4'd0, 4'd10, 1'b0}, '{2'b10, 1'b0, 4'd0, 4'd12, 1'b0},
      '{2'b10, 1'b0, 4'd0, 4'd14, 1'b0}, '{2'b10, 1'b0, 4'd0, 4'd0,  1'b1},
      '{2'b11, 1'b0, 4'd0, 4'd14, 1'b1}, '{2'b11, 1'b0, 4'd0, 4'd12, 1'b0},
      '{2'b11, 1'b0, 4'd0, 4'd10, 1'b0}, '{2'b01, 1'b0, 4'd0, 4'd11, 1'b0},
      '{2'b01, 1'b0, 4'd0, 4'd12, 1'b0}, '{2'b01, 1'b1, 4'd5, 4'd5,  1'b0},
      '{2'b10, 1'b0, 4'd0, 4'd7,  1'b0}
    };

    // Reset held across edges, then first tick on the DIV-th edge.
    repeat (2) @(negedge clk);
    check("rst_q", 32'(bus_w.Q), 32'd0);
    check("rst_tc", 32'(bus_w.tc), 32'd0);
    check("rst_tick", 32'(bus_w.tick), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= DIV; i++) begin
      step();
      check("first_tick", 32'(bus_w.tick), (i == DIV) ? 32'd1 : 32'd0);
    end

    // Load 6, then drop reset between edges.
    load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0;
    check("load6", 32'(bus_w.Q), 32'd6);
    repeat (2) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(bus_w.Q), 32'd0);
    check("async_rst_q_sat", 32'(bus_s.Q), 32'd0);
    check("async_rst_tc", 32'(bus_w.tc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= DIV; i++) begin
      step();
      check("first_tick_again", 32'(bus_w.tick), (i == DIV) ? 32'd1 : 32'd0);
    end

    // Table: up-STEP wrap, down wrap, mode switch, load on a tick.
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      next_count(vecs[i].ld, vecs[i].lv);
      check("vec_q", 32'(bus_w.Q), 32'(vecs[i].exp_q));
      check("vec_tc", 32'(bus_w.tc), 32'(vecs[i].exp_tc));
    end

    // Saturating instance at both limits.
    sel = 2'b01;
    next_count(1'b1, 4'd13);
    check("sat_load13", 32'(bus_s.Q), 32'd13);
    next_count(1'b0, '0); check("sat_q14", 32'(bus_s.Q), 32'd14); check("sat_tc14", 32'(bus_s.tc), 32'd0);
    next_count(1'b0, '0); check("sat_q15", 32'(bus_s.Q), 32'd15); check("sat_tc15", 32'(bus_s.tc), 32'd0);
    next_count(1'b0, '0); check("sat_hi_q", 32'(bus_s.Q), 32'd15); check("sat_hi_tc", 32'(bus_s.tc), 32'd1);
    next_count(1'b0, '0); check("sat_hi_q2", 32'(bus_s.Q), 32'd15); check("sat_hi_tc2", 32'(bus_s.tc), 32'd1);
    sel = 2'b11;
    next_count(1'b1, 4'd1);
    next_count(1'b0, '0); check("sat_lo_q", 32'(bus_s.Q), 32'd0); check("sat_lo_tc", 32'(bus_s.tc), 32'd1);
    check("wrap_lo_q", 32'(bus_w.Q), 32'd15);
    next_count(1'b0, '0); check("sat_lo_q2", 32'(bus_s.Q), 32'd0); check("sat_lo_tc2", 32'(bus_s.tc), 32'd1);

    // Load and sync_clr together: clear wins, prescaler restarts.
    sync_clr = 1'b1; load = 1'b1; load_val = 4'd9;
    step();
    sync_clr = 1'b0; load = 1'b0;
    check("clr_q", 32'(bus_w.Q), 32'd0);
    check("clr_q_sat", 32'(bus_s.Q), 32'd0);
    check("clr_tick", 32'(bus_w.tick), 32'd0);
    for (int i = 1; i <= DIV; i++) begin
      step();
      check("clr_tick_phase", 32'(bus_w.tick), (i == DIV) ? 32'd1 : 32'd0);
    end

    // Freeze with en=0 mid-phase, then resume from the same phase.
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0; load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b0; sel = 2'b01;
    for (int i = 0; i < 20; i++) begin
      step();
      check("frz_q", 32'(bus_w.Q), 32'd9);
      check("frz_tick", 32'(bus_w.tick), 32'd0);
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("frz_resume_tick", 32'(bus_w.tick), (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    check("frz_resume_q", 32'(bus_w.Q), 32'd10);

    // Hold mode across several ticks.
    sel = 2'b00;
    for (int i = 0; i < 5; i++) begin
      next_count(1'b0, '0);
      check("hold_q", 32'(bus_w.Q), 32'd10);
      check("hold_tc", 32'(bus_w.tc), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      sel      = 2'($urandom);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom);
      sync_clr = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
